// File: rtl/serial_rx.sv
// UART-style receiver: 1 start bit, Width data bits LSB first, 1 stop bit,
// bit period 2^TimerWidth clocks. Emits one-cycle valid / frame_error strobes.
module serial_rx #(
    parameter int unsigned Width      = 8,
    parameter int unsigned TimerWidth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [Width-1:0] data,
    output logic             valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned CntWidth = $clog2(Width + 1);
    localparam logic [TimerWidth-1:0] TimerLast = '1;
    localparam logic [TimerWidth-1:0] TimerHalf = TimerWidth'((1 << (TimerWidth - 1)) - 1);
    localparam logic [CntWidth-1:0]   CntLast   = CntWidth'(Width - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [Width-1:0]      shift_q, shift_d;
    logic [Width-1:0]      data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  rx_m_q, rx_s_q, rx_p_q;

    // Synchronizer plus one history flop; reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_p_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            rx_p_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (rx_p_q && !rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_q == TimerHalf) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (timer_q == TimerLast) begin
                    timer_d            = '0;
                    // Shift right so the first (LSB) bit ends up in bit 0.
                    shift_d            = shift_q >> 1;
                    shift_d[Width-1]   = rx_s_q;
                    cnt_d              = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (timer_q == TimerLast) begin
                    // Return mid-stop-bit so a zero-gap next start bit is caught.
                    timer_d = '0;
                    state_d = StIdle;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a behavioural serializer drives rx, expected frames go
// into a scoreboard queue and are matched against valid / frame_error strobes.
module tb_serial_rx;

    localparam int unsigned Width      = 8;
    localparam int unsigned TimerWidth = 2;
    localparam int         T          = 1 << TimerWidth;
    localparam int         H          = T / 2;

    logic             clk;
    logic             rst;
    logic             rx;
    logic [Width-1:0] data;
    logic             valid;
    logic             frame_error;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entry: bit 8 set = framing error expected, else good word.
    logic [8:0] sb_q[$];
    logic [7:0] model_data = 8'h00;
    int         cycle      = 0;
    int         busy_cnt   = 0;
    int         valid_times[$];
    logic       prev_pulse = 1'b0;

    serial_rx #(
        .Width      (Width),
        .TimerWidth (TimerWidth)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: sample away from the rising edge.
    always @(negedge clk) begin
        logic [8:0] e;
        cycle++;
        if (busy === 1'b1) busy_cnt++;
        if (valid === 1'b1 || frame_error === 1'b1) begin
            check_eq("excl", {31'b0, valid && frame_error}, 32'd0);
            check_eq("single_cycle", {31'b0, prev_pulse}, 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (valid === 1'b1) begin
                    check_eq("kind_valid", {31'b0, e[8]}, 32'd0);
                    check_eq("data", {24'b0, data}, {24'b0, e[7:0]});
                    model_data = e[7:0];
                    valid_times.push_back(cycle);
                end else begin
                    check_eq("kind_ferr", {31'b0, e[8]}, 32'd1);
                    check_eq("data_hold", {24'b0, data}, {24'b0, model_data});
                end
            end
        end
        prev_pulse = (valid === 1'b1) || (frame_error === 1'b1);
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits of {stop, d, start} LSB first.
    task automatic send(input logic [7:0] d, input logic stop, input int nbits);
        logic [9:0] seq;
        seq = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = seq[i];
            repeat (T) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        sb_q.push_back({1'b0, d});
        send(d, 1'b1, 10);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_data", {24'b0, data}, 32'd0);
        check_eq("rst_valid", {31'b0, valid}, 32'd0);
        check_eq("rst_ferr", {31'b0, frame_error}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        idle(5);

        // Single frame; busy spans H + (Width+1)*T clocks.
        busy_cnt = 0;
        send_good(8'hA5);
        idle(12);
        check_eq("busy_len", busy_cnt, H + (Width + 1) * T);
        check_eq("a5_data", {24'b0, data}, 32'h0000_00A5);

        // Back-to-back, no idle gap.
        valid_times.delete();
        send_good(8'h00);
        send_good(8'hFF);
        idle(12);
        check_eq("b2b_count", valid_times.size(), 2);
        if (valid_times.size() == 2)
            check_eq("b2b_gap", valid_times[1] - valid_times[0], 10 * T);

        // One-clock glitch: busy for H clocks only.
        busy_cnt = 0;
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle(15);
        check_eq("glitch_busy", busy_cnt, H);
        check_eq("glitch_data", {24'b0, data}, 32'h0000_00FF);

        // Framing error then line held low: no retrigger.
        busy_cnt = 0;
        sb_q.push_back(9'h100);
        send(8'h3C, 1'b0, 10);
        repeat (50) @(posedge clk);
        #1;
        check_eq("ferr_busy", busy_cnt, H + (Width + 1) * T);
        idle(12);
        check_eq("ferr_data", {24'b0, data}, 32'h0000_00FF);

        // Reset during data bit 3 of 0x5A.
        send(8'h5A, 1'b1, 4);
        rx = 1'b1;  // bit 3 of 0x5A
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_data = 8'h00;
        check_eq("mid_rst_data", {24'b0, data}, 32'd0);
        check_eq("mid_rst_valid", {31'b0, valid}, 32'd0);
        check_eq("mid_rst_ferr", {31'b0, frame_error}, 32'd0);
        check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
        idle(10);
        send_good(8'h81);
        idle(12);
        check_eq("post_rst_data", {24'b0, data}, 32'h0000_0081);

        // Loopback-style stream of random bytes with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            send_good(b);
            idle($urandom_range(0, 3) * T);
        end
        idle(20);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

UART-style serial receiver that sits directly downstream of SerialTx. It recovers Width-bit words from the single-wire `rx` line: 1 start bit (low), Width data bits LSB first, 1 stop bit (high), at a bit period of 2^TimerWidth clocks. Each received word is presented on `data` with a one-cycle `valid` strobe for the consuming logic. A SerialTx/serial_rx pair built with equal Width and TimerWidth forms a loopback link.

## Interface
- Width, 8, data bits per frame (≥1).
- TimerWidth, 2, bit period T = 2^TimerWidth clocks; half period H = T/2 (TimerWidth ≥ 2).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  Width  last correctly framed word; holds until next good frame.
- valid  output  1  one-cycle pulse, `data` updated this cycle.
- frame_error  output  1  one-cycle pulse, stop bit sampled low.
- busy  output  1  high while a frame is being received.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchronizer (rx_s), plus one history flop (rx_p) for edge detect.
- Reset (rst=1 at a clock edge): state IDLE, timer 0, bit counter 0, shift register 0, data 0, valid 0, frame_error 0, busy 0, synchronizer and history flops 1. Reset mid-frame abandons the frame with no pulse on any output.
- States:
  - IDLE: on rx_p=1 and rx_s=0 (falling edge) → START, timer←0. A line held low does not retrigger.
  - START: timer counts; at timer=H−1 sample rx_s. If 1 (glitch) → IDLE, no outputs. If 0 → DATA, timer←0, bit counter←0.
  - DATA: at timer=T−1 sample rx_s into the shift register (shift right, new bit into MSB, so LSB-first arrival lands correctly), timer←0, bit counter+1; after Width samples → STOP.
  - STOP: at timer=T−1 sample rx_s. If 1: data←shift register, valid=1 next cycle. If 0: frame_error=1 next cycle, data unchanged. Either way → IDLE immediately (mid-stop-bit), allowing back-to-back frames.
- busy = 1 in START, DATA, STOP; 0 in IDLE.
- valid and frame_error are mutually exclusive and never high more than one consecutive cycle.
- Timer is TimerWidth bits, bit counter is ceil(log2(Width+1)) bits. Neither wraps inside a state.

## Timing
- Edge k = the clock edge at which IDLE detects the falling edge on rx_s. This is 2–3 clocks after the physical `rx` fall because of the synchronizer.
- busy rises after edge k.
- Start-bit check at edge k+H.
- Data bit i (i = 0..Width−1) sampled at edge k+H+(i+1)·T, which is mid-bit.
- Stop bit sampled at edge k+H+(Width+1)·T. valid or frame_error is high for exactly the following cycle, and busy falls on the same edge.
- Earliest next start detection is one clock after returning to IDLE, so a start bit following a stop bit with zero idle gap is caught.
- Tolerates ±H/(Width+1.5) clocks of accumulated bit-period error.

## Test plan
- Single frame, TimerWidth=2 (T=4): drive 0xA5 LSB first at 4 clocks/bit. Expect valid pulse once, data=0xA5, frame_error never high, busy high from edge k to the stop-sample edge.
- Back-to-back frames 0x00 then 0xFF with no idle gap. Expect two valid pulses exactly 10·T=40 clocks apart, carrying 0x00 then 0xFF.
- Glitch: rx low for 1 clock, then high. Expect busy high for H clocks then low, no valid, no frame_error, data unchanged.
- Framing error: send 0x3C with stop bit low, then hold rx low 50 clocks. Expect one frame_error pulse, no valid, data still holds the previous value, no retrigger while the line stays low.
- Reset mid-frame: assert rst for 1 clock during data bit 3 of 0x5A, then send 0x81 cleanly. Expect all outputs 0 the cycle after reset, no pulse for the aborted frame, then valid with data=0x81.
- Loopback: connect SerialTx(Width=8, TimerWidth=2) tx → rx and send 20 `$random` bytes. Each byte reappears on data with valid, in order.
